// File: rtl/nbody_pkg.sv
// ----------------------------------------------------------------------------
// nbody_pkg
// Shared constants and types for the pairwise-acceleration scheduler.
//   - FP operator latencies and the derived datapath / tag-pipe latencies
//   - sched_state_t : scheduler FSM states
//   - body_idx_t    : body index type (address width)
// ----------------------------------------------------------------------------
package nbody_pkg;

    localparam int MAX_BODIES   = 256;
    localparam int IDX_W        = $clog2(MAX_BODIES);

    localparam int MULT_TIME    = 11;
    localparam int ADD_TIME     = 20;
    localparam int INVSQRT_TIME = 27;
    localparam int RD_LAT       = 1;

    // Full datapath depth: one setup stage, two add/sub layers, five
    // multiply layers and the inverse square root.
    localparam int ACCL_LAT     = 1 + 2 * ADD_TIME + 5 * MULT_TIME + INVSQRT_TIME;

    // Issue-to-datapath-output distance: memory read plus datapath.
    localparam int TAG_LAT      = RD_LAT + ACCL_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } sched_state_t;

    typedef logic [IDX_W-1:0] body_idx_t;

endpackage

// File: rtl/accl_tag_pipe.sv
// ----------------------------------------------------------------------------
// accl_tag_pipe
// Fixed-depth shift register carrying {valid, idx, last} alongside the
// acceleration datapath so each result leaves tagged with its body index.
// Ports:
//   i_clk    in   1      clock
//   i_rst    in   1      asynchronous active-high reset
//   i_flush  in   1      synchronous clear of every valid bit
//   i_valid  in   1      tag entry valid (issue strobe)
//   i_idx    in   IDX_W  body i of the issued pair
//   i_last   in   1      issued pair has j = N-1
//   o_valid  out  1      tag emerging after DEPTH cycles
//   o_idx    out  IDX_W  body i of the emerging tag
//   o_last   out  1      last-j flag of the emerging tag
// ----------------------------------------------------------------------------
module accl_tag_pipe #(
    parameter int DEPTH = 124,
    parameter int IDX_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;
    logic [IDX_W-1:0] r_idx [DEPTH];

    // Valid bits: shifted every cycle, cleared by flush so flushed pairs vanish.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= {DEPTH{1'b0}};
        end else if (i_flush) begin
            r_valid <= {DEPTH{1'b0}};
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], i_valid};
        end
    end

    // Payload: shifted unconditionally; meaningless wherever valid is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                r_idx[k] <= {IDX_W{1'b0}};
            end
        end else begin
            r_last   <= {r_last[DEPTH-2:0], i_last};
            r_idx[0] <= i_idx;
            for (int k = 1; k < DEPTH; k++) begin
                r_idx[k] <= r_idx[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/accl_pair_scheduler.sv
// ----------------------------------------------------------------------------
// accl_pair_scheduler
// Walks all N*N body pairs (i,j), one per cycle, into the body memory read
// ports feeding the pipelined acceleration datapath, and re-tags the datapath
// output into a result stream (body i, last-j flag) for the accumulator.
// Ports:
//   clk        in   1        clock
//   rst        in   1        asynchronous active-high reset
//   start      in   1        start pulse, honoured only when idle
//   n_bodies   in   IDX_W+1  body count N, sampled on an accepted start
//   abort      in   1        synchronous flush of the running pass
//   busy       out  1        pass in progress
//   done       out  1        one-cycle pass-complete pulse
//   rd_en      out  1        pair issue strobe to body memory
//   rd_addr_i  out  IDX_W    address of body i
//   rd_addr_j  out  IDX_W    address of body j
//   accl_ax    in   64       datapath x acceleration
//   accl_ay    in   64       datapath y acceleration
//   res_valid  out  1        result strobe (no backpressure)
//   res_body   out  IDX_W    body i of the result
//   res_last   out  1        result is the j = N-1 term for body i
//   res_ax     out  64       registered accl_ax
//   res_ay     out  64       registered accl_ay
// ----------------------------------------------------------------------------
module accl_pair_scheduler
    import nbody_pkg::*;
#(
    parameter int MAX_BODIES = nbody_pkg::MAX_BODIES,
    parameter int IDX_W      = $clog2(MAX_BODIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   n_bodies,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr_i,
    output logic [IDX_W-1:0] rd_addr_j,
    input  logic [63:0]      accl_ax,
    input  logic [63:0]      accl_ay,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_body,
    output logic             res_last,
    output logic [63:0]      res_ax,
    output logic [63:0]      res_ay
);

    localparam int             CNT_W   = $clog2(TAG_LAT + 1);
    localparam logic [IDX_W:0] IDX_ONE = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0] IDX_ZERO = {(IDX_W+1){1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;

    // i, j and N-1 carry one extra bit so N = MAX_BODIES compares cleanly.
    logic [IDX_W:0]   r_i;
    logic [IDX_W:0]   r_j;
    logic [IDX_W:0]   r_nm1;

    logic [CNT_W-1:0] r_outstanding;

    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic             r_res_valid;
    logic [IDX_W-1:0] r_res_body;
    logic             r_res_last;
    logic [63:0]      r_res_ax;
    logic [63:0]      r_res_ay;

    logic             w_flush;
    logic             w_accept;
    logic             w_last_issue;
    logic             w_tag_valid;
    logic [IDX_W-1:0] w_tag_idx;
    logic             w_tag_last;

    // Abort only has an effect once a pass has left IDLE.
    assign w_flush      = abort && (r_state != IDLE);
    assign w_accept     = (r_state == IDLE) && start && !abort && (n_bodies != IDX_ZERO);
    assign w_last_issue = (r_i == r_nm1) && (r_j == r_nm1);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    if (n_bodies == IDX_ZERO) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last_issue) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                // The pair leaving the pipe last is in res_* this cycle, so
                // an empty pipe means the final result is being delivered now.
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_outstanding == CNT_ZERO) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == FIN);
            r_rd_en <= (w_state_nxt == RUN);
        end
    end

    // Pair counters: j is the inner loop, i advances when j wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i   <= IDX_ZERO;
            r_j   <= IDX_ZERO;
            r_nm1 <= IDX_ZERO;
        end else if (w_flush) begin
            r_i <= IDX_ZERO;
            r_j <= IDX_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_nm1 <= n_bodies - IDX_ONE;
                        r_i   <= IDX_ZERO;
                        r_j   <= IDX_ZERO;
                    end else begin
                        r_nm1 <= r_nm1;
                    end
                end
                RUN: begin
                    if (r_j == r_nm1) begin
                        r_j <= IDX_ZERO;
                        if (r_i == r_nm1) begin
                            r_i <= IDX_ZERO;
                        end else begin
                            r_i <= r_i + IDX_ONE;
                        end
                    end else begin
                        r_j <= r_j + IDX_ONE;
                    end
                end
                default: begin
                    r_i <= r_i;
                    r_j <= r_j;
                end
            endcase
        end
    end

    accl_tag_pipe #(
        .DEPTH (TAG_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (w_flush),
        .i_valid (r_rd_en),
        .i_idx   (r_i[IDX_W-1:0]),
        .i_last  (r_j == r_nm1),
        .o_valid (w_tag_valid),
        .o_idx   (w_tag_idx),
        .o_last  (w_tag_last)
    );

    // Pairs currently inside the tag pipe; zero marks the end of draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= CNT_ZERO;
        end else if (w_flush) begin
            r_outstanding <= CNT_ZERO;
        end else begin
            case ({r_rd_en, w_tag_valid})
                2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Result register: tag output paired with the datapath output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_body  <= {IDX_W{1'b0}};
            r_res_last  <= 1'b0;
            r_res_ax    <= 64'd0;
            r_res_ay    <= 64'd0;
        end else begin
            r_res_valid <= w_tag_valid && !w_flush;
            r_res_body  <= w_tag_idx;
            r_res_last  <= w_tag_valid && w_tag_last && !w_flush;
            r_res_ax    <= accl_ax;
            r_res_ay    <= accl_ay;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr_i = r_i[IDX_W-1:0];
    assign rd_addr_j = r_j[IDX_W-1:0];
    assign res_valid = r_res_valid;
    assign res_body  = r_res_body;
    assign res_last  = r_res_last;
    assign res_ax    = r_res_ax;
    assign res_ay    = r_res_ay;

endmodule

// File: tb/tb_accl_pair_scheduler.sv
// ----------------------------------------------------------------------------
// tb_accl_pair_scheduler
// Directed bench for accl_pair_scheduler. Cycle c of a pass is the c-th cycle
// after the clock edge that sampled start; outputs are sampled on the falling
// edge. Results appear 125 cycles after their issue (issue cycle 1 -> 126).
// ----------------------------------------------------------------------------
module tb_accl_pair_scheduler;

    localparam int IW      = 8;
    localparam int RES_OFF = 126;   // first result cycle when issue starts at cycle 1

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [IW:0]   n_bodies;
    logic [63:0]   accl_ax;
    logic [63:0]   accl_ay;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [IW-1:0] rd_addr_i;
    logic [IW-1:0] rd_addr_j;
    logic          res_valid;
    logic [IW-1:0] res_body;
    logic          res_last;
    logic [63:0]   res_ax;
    logic [63:0]   res_ay;

    int            tests = 0;
    int            fails = 0;
    logic [31:0]   gcyc  = 32'd0;

    accl_pair_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_bodies  (n_bodies),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_i (rd_addr_i),
        .rd_addr_j (rd_addr_j),
        .accl_ax   (accl_ax),
        .accl_ay   (accl_ay),
        .res_valid (res_valid),
        .res_body  (res_body),
        .res_last  (res_last),
        .res_ax    (res_ax),
        .res_ay    (res_ay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Present fresh datapath data for the current cycle, then move to the next cycle.
    task automatic advance();
        gcyc    = gcyc + 32'd1;
        accl_ax = {32'hC0DE_0A00, gcyc};
        accl_ay = {32'h5EED_0B00, ~gcyc};
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy,      64'd0);
        chk({tag, "_done"},  done,      64'd0);
        chk({tag, "_rd_en"}, rd_en,     64'd0);
        chk({tag, "_ai"},    rd_addr_i, 64'd0);
        chk({tag, "_aj"},    rd_addr_j, 64'd0);
        chk({tag, "_rv"},    res_valid, 64'd0);
        chk({tag, "_rb"},    res_body,  64'd0);
        chk({tag, "_rl"},    res_last,  64'd0);
        chk({tag, "_rax"},   res_ax,    64'd0);
        chk({tag, "_ray"},   res_ay,    64'd0);
    endtask

    // Full pass of N bodies started now; optionally pulse start (N=5) mid-RUN.
    task automatic run_full(input int n, input bit mid);
        int nn       = n * n;
        int res_cnt  = 0;
        int done_cnt = 0;
        int k;
        int r;
        bit exp_rd;
        bit exp_rv;
        n_bodies = n[IW:0];
        start    = 1'b1;
        advance();
        start    = 1'b0;
        for (int c = 1; c <= nn + 130; c++) begin
            k      = c - 1;
            r      = c - RES_OFF;
            exp_rd = (k < nn);
            exp_rv = (r >= 0) && (r < nn);
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) begin
                chk("rd_addr_i", rd_addr_i, k / n);
                chk("rd_addr_j", rd_addr_j, k % n);
            end
            chk("res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                chk("res_body", res_body, r / n);
                chk("res_last", res_last, (r % n) == (n - 1));
                chk("res_ax", res_ax, accl_ax);
                chk("res_ay", res_ay, accl_ay);
            end else begin
                chk("res_last_idle", res_last, 64'd0);
            end
            chk("done", done, c == nn + RES_OFF);
            chk("busy", busy, c <= nn + RES_OFF);
            if (res_valid === 1'b1) res_cnt++;
            if (done === 1'b1) done_cnt++;
            if (mid && c == 4) begin
                start    = 1'b1;
                n_bodies = 9'd5;
            end else if (mid && c == 5) begin
                start    = 1'b0;
                n_bodies = n[IW:0];
            end
            advance();
        end
        chk("res_count", res_cnt, nn);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int first_done;
        int done_cnt;
        int rv_cnt;
        int rd_cnt;

        // ---- reset state ----
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        n_bodies = 9'd0;
        accl_ax  = 64'hDEAD_BEEF_0123_4567;
        accl_ay  = 64'h89AB_CDEF_FEED_FACE;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        advance();
        chk("idle_busy", busy, 64'd0);

        // ---- N=3 basic pass ----
        run_full(3, 1'b0);

        // ---- N=0: done only, no issue, no result ----
        n_bodies   = 9'd0;
        start      = 1'b1;
        advance();
        start      = 1'b0;
        first_done = 0;
        done_cnt   = 0;
        rv_cnt     = 0;
        rd_cnt     = 0;
        for (int c = 1; c <= 5; c++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            if (res_valid === 1'b1) rv_cnt++;
            if (rd_en === 1'b1) rd_cnt++;
            advance();
        end
        chk("n0_done_count", done_cnt, 1);
        chk("n0_done_early", (first_done >= 1) && (first_done <= 2), 64'd1);
        chk("n0_no_rd", rd_cnt, 0);
        chk("n0_no_res", rv_cnt, 0);
        chk("n0_busy_end", busy, 64'd0);

        // ---- N=1 ----
        run_full(1, 1'b0);

        // ---- start and abort together while idle: abort wins ----
        n_bodies = 9'd3;
        start    = 1'b1;
        abort    = 1'b1;
        advance();
        start    = 1'b0;
        abort    = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("sa_busy", busy, 64'd0);
            chk("sa_rd_en", rd_en, 64'd0);
            advance();
        end

        // ---- start re-pulsed mid-RUN is ignored ----
        run_full(3, 1'b1);

        // ---- abort at the 4th issue of N=3 ----
        n_bodies = 9'd3;
        start    = 1'b1;
        advance();
        start    = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("ab_rd_en", rd_en, 64'd1);
            if (c == 4) begin
                chk("ab_ai", rd_addr_i, 64'd1);
                chk("ab_aj", rd_addr_j, 64'd0);
                abort = 1'b1;
            end
            advance();
        end
        abort    = 1'b0;
        rv_cnt   = 0;
        done_cnt = 0;
        for (int c = 5; c <= 140; c++) begin
            if (res_valid === 1'b1) rv_cnt++;
            if (done === 1'b1) done_cnt++;
            if (c == 5) begin
                chk("ab_busy", busy, 64'd0);
                chk("ab_rd_off", rd_en, 64'd0);
            end
            advance();
        end
        chk("ab_no_res", rv_cnt, 0);
        chk("ab_no_done", done_cnt, 0);

        // ---- clean pass after abort ----
        run_full(2, 1'b0);

        // ---- reset asserted during DRAIN ----
        n_bodies = 9'd2;
        start    = 1'b1;
        advance();
        start    = 1'b0;
        for (int c = 1; c < 60; c++) advance();
        chk("rd_drain_busy", busy, 64'd1);
        chk("rd_drain_rd_en", rd_en, 64'd0);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_drain");
        advance();
        rst      = 1'b0;
        rv_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c < 160; c++) begin
            if (res_valid === 1'b1) rv_cnt++;
            if (done === 1'b1) done_cnt++;
            advance();
        end
        chk("rst_no_stale_res", rv_cnt, 0);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_busy", busy, 64'd0);

        // ---- N = MAX_BODIES ----
        run_full(256, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
